// File: rtl/bp_fe_pkg.sv
// Front-end realigner package: state encoding, instruction record and RVC test.
package bp_fe_pkg;

    // Width of the pc field carried in the instruction record.
    localparam int bp_fe_vaddr_width_gp = 39;

    typedef enum logic [1:0] {
        e_rlgn_empty   = 2'd0,
        e_rlgn_partial = 2'd1,
        e_rlgn_cpend   = 2'd2
    } bp_fe_realign_state_e;

    typedef struct packed {
        logic [31:0]                     instr;
        logic [bp_fe_vaddr_width_gp-1:0] pc;
        logic                            compressed;
        logic                            straddle;
    } bp_fe_realign_instr_s;

    // A halfword starts an RVC instruction unless its two low bits are both set.
    function automatic logic bp_fe_is_rvc(input logic [15:0] h);
        return (h & 16'h0003) != 16'h0003;
    endfunction

endpackage

// File: rtl/bp_fe_realigner_outreg.sv
// Single-entry output register with load / hold / flush.
// Loads when load_i, drops its entry when the consumer accepts, clears on flush_i.
// The caller only asserts load_i when the register is free or being drained.
module bp_fe_realigner_outreg #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               ready_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               v_d, v_q;
    logic [width_p-1:0] data_d, data_q;

    // Next-state for valid/data: flush wins, then load, then drain on accept.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d    = 1'b1;
            data_d = data_i;
        end else if (ready_i) begin
            v_d = 1'b0;
        end
    end

    // Register update with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule

// File: rtl/bp_fe_fetch_realigner.sv
// Fetch realigner: turns raw 32b I$ words into whole 16b/32b RV64 instructions.
// Holds the upper halfword of a consumed word, joins 32b instructions that
// straddle two words, and splits a word carrying two RVC instructions.
// Optional build macro BP_FE_REALIGNER_PERF_EN adds saturating counters of
// accepted compressed and straddling instructions.
module bp_fe_fetch_realigner
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = bp_fe_vaddr_width_gp
`ifdef BP_FE_REALIGNER_PERF_EN
    , parameter int perf_cnt_width_p = 32
`endif
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     fetch_v_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic [31:0]              fetch_data_i,
    output logic                     fetch_ready_o,
    output logic                     instr_v_o,
    output logic [31:0]              instr_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic                     instr_compressed_o,
    output logic                     instr_straddle_o,
    input  logic                     instr_ready_i,
`ifdef BP_FE_REALIGNER_PERF_EN
    output logic [perf_cnt_width_p-1:0] perf_rvc_cnt_o,
    output logic [perf_cnt_width_p-1:0] perf_straddle_cnt_o,
`endif
    output logic                     partial_o
);

    bp_fe_realign_state_e       state_d, state_q;
    logic [15:0]                held_d, held_q;
    logic [vaddr_width_p-1:0]   held_pc_d, held_pc_q;

    logic                       out_free;
    logic                       consume;
    logic                       load;
    logic                       out_v;
    bp_fe_realign_instr_s       emit;
    bp_fe_realign_instr_s       out;

    logic [15:0]                lo_half, hi_half;
    logic [vaddr_width_p-1:0]   pc_plus2, held_pc_plus2;
    logic                       join_match;

    assign lo_half       = fetch_data_i[15:0];
    assign hi_half       = fetch_data_i[31:16];
    assign pc_plus2      = fetch_pc_i + vaddr_width_p'(2);
    assign held_pc_plus2 = held_pc_q + vaddr_width_p'(2);
    assign join_match    = (state_q == e_rlgn_partial) && (fetch_pc_i == held_pc_plus2);

    // The output slot is usable when empty or being accepted this cycle.
    // A held RVC must drain before another word can be taken.
    assign out_free      = ~out_v | instr_ready_i;
    assign fetch_ready_o = reset_n_i & out_free & (state_q != e_rlgn_cpend) & ~flush_i;
    assign consume       = fetch_v_i & fetch_ready_o;

    // Next-state, held halfword and emitted instruction for this cycle.
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        held_pc_d = held_pc_q;
        load      = 1'b0;
        emit      = '0;
        if (flush_i) begin
            state_d = e_rlgn_empty;
        end else if (state_q == e_rlgn_cpend) begin
            if (out_free) begin
                load            = 1'b1;
                emit.instr      = {16'h0000, held_q};
                emit.pc         = bp_fe_vaddr_width_gp'(held_pc_q);
                emit.compressed = 1'b1;
                state_d         = e_rlgn_empty;
            end
        end else if (consume) begin
            if (join_match) begin
                // Complete the held upper part with this word's low half,
                // then the new upper half is treated like a fresh one at pc+2.
                load            = 1'b1;
                emit.instr      = {lo_half, held_q};
                emit.pc         = bp_fe_vaddr_width_gp'(held_pc_q);
                emit.compressed = bp_fe_is_rvc(held_q);
                emit.straddle   = 1'b1;
                held_d          = hi_half;
                held_pc_d       = pc_plus2;
                state_d         = bp_fe_is_rvc(hi_half) ? e_rlgn_cpend : e_rlgn_partial;
            end else if (!fetch_pc_i[1]) begin
                // Aligned word; any stale held half (pc mismatch) is discarded.
                load    = 1'b1;
                emit.pc = bp_fe_vaddr_width_gp'(fetch_pc_i);
                if (!bp_fe_is_rvc(lo_half)) begin
                    emit.instr = fetch_data_i;
                    state_d    = e_rlgn_empty;
                end else begin
                    emit.instr      = {16'h0000, lo_half};
                    emit.compressed = 1'b1;
                    held_d          = hi_half;
                    held_pc_d       = pc_plus2;
                    state_d         = bp_fe_is_rvc(hi_half) ? e_rlgn_cpend : e_rlgn_partial;
                end
            end else begin
                // Misaligned redirect target: only the upper half is live.
                if (bp_fe_is_rvc(hi_half)) begin
                    load            = 1'b1;
                    emit.instr      = {16'h0000, hi_half};
                    emit.pc         = bp_fe_vaddr_width_gp'(fetch_pc_i);
                    emit.compressed = 1'b1;
                    state_d         = e_rlgn_empty;
                end else begin
                    held_d    = hi_half;
                    held_pc_d = fetch_pc_i;
                    state_d   = e_rlgn_partial;
                end
            end
        end
    end

    // State and held-halfword registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_rlgn_empty;
            held_q    <= '0;
            held_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            held_pc_q <= held_pc_d;
        end
    end

    bp_fe_realigner_outreg #(
        .width_p ($bits(bp_fe_realign_instr_s))
    ) outreg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .load_i    (load),
        .ready_i   (instr_ready_i),
        .data_i    (emit),
        .v_o       (out_v),
        .data_o    (out)
    );

    assign instr_v_o          = out_v;
    assign instr_o            = out.instr;
    assign instr_pc_o         = vaddr_width_p'(out.pc);
    assign instr_compressed_o = out.compressed;
    assign instr_straddle_o   = out.straddle;
    assign partial_o          = (state_q == e_rlgn_partial);

`ifdef BP_FE_REALIGNER_PERF_EN
    logic [perf_cnt_width_p-1:0] perf_rvc_cnt_d, perf_rvc_cnt_q;
    logic [perf_cnt_width_p-1:0] perf_straddle_cnt_d, perf_straddle_cnt_q;
    logic                        accept;

    function automatic logic [perf_cnt_width_p-1:0] sat_inc(input logic [perf_cnt_width_p-1:0] c);
        return (&c) ? c : c + perf_cnt_width_p'(1);
    endfunction

    assign accept = out_v & instr_ready_i;

    // Count accepted instructions by kind; counters stick at all-ones.
    always_comb begin
        perf_rvc_cnt_d      = (accept & out.compressed) ? sat_inc(perf_rvc_cnt_q) : perf_rvc_cnt_q;
        perf_straddle_cnt_d = (accept & out.straddle) ? sat_inc(perf_straddle_cnt_q) : perf_straddle_cnt_q;
    end

    // Counter registers; untouched by flush.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_rvc_cnt_q      <= '0;
            perf_straddle_cnt_q <= '0;
        end else begin
            perf_rvc_cnt_q      <= perf_rvc_cnt_d;
            perf_straddle_cnt_q <= perf_straddle_cnt_d;
        end
    end

    assign perf_rvc_cnt_o      = perf_rvc_cnt_q;
    assign perf_straddle_cnt_o = perf_straddle_cnt_q;
`endif

endmodule

// File: tb/tb_bp_fe_fetch_realigner.sv
// Self-checking bench for bp_fe_fetch_realigner: expected instructions are
// queued as words are driven and compared as the DUT hands them downstream.
module tb_bp_fe_fetch_realigner;

    logic        clk;
    logic        reset_n;
    logic        flush_i;
    logic        fetch_v_i;
    logic [38:0] fetch_pc_i;
    logic [31:0] fetch_data_i;
    logic        fetch_ready_o;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic [38:0] instr_pc_o;
    logic        instr_compressed_o;
    logic        instr_straddle_o;
    logic        instr_ready_i;
    logic        partial_o;
`ifdef BP_FE_REALIGNER_PERF_EN
    logic [31:0] perf_rvc_cnt_o;
    logic [31:0] perf_straddle_cnt_o;
`endif

    bp_fe_fetch_realigner #(
        .vaddr_width_p (39)
`ifdef BP_FE_REALIGNER_PERF_EN
        , .perf_cnt_width_p (32)
`endif
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .flush_i            (flush_i),
        .fetch_v_i          (fetch_v_i),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_data_i       (fetch_data_i),
        .fetch_ready_o      (fetch_ready_o),
        .instr_v_o          (instr_v_o),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o),
        .instr_straddle_o   (instr_straddle_o),
        .instr_ready_i      (instr_ready_i),
`ifdef BP_FE_REALIGNER_PERF_EN
        .perf_rvc_cnt_o      (perf_rvc_cnt_o),
        .perf_straddle_cnt_o (perf_straddle_cnt_o),
`endif
        .partial_o          (partial_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        c;
        logic        s;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rvc = 0;
    int   n_str = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_push(input logic [31:0] instr, input logic [63:0] pc, input logic c, input logic s);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.c     = c;
        e.s     = s;
        sb_q.push_back(e);
    endtask

    // Compare every instruction the downstream side accepts.
    always @(negedge clk) begin
        if (reset_n && instr_v_o && instr_ready_i) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {32'h0, instr_o}, 64'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("instr", {32'h0, instr_o}, {32'h0, mon_e.instr});
                check("instr_pc", {25'h0, instr_pc_o}, mon_e.pc);
                check("compressed", {63'h0, instr_compressed_o}, {63'h0, mon_e.c});
                check("straddle", {63'h0, instr_straddle_o}, {63'h0, mon_e.s});
                if (mon_e.c) n_rvc++;
                if (mon_e.s) n_str++;
            end
        end
    end

    task automatic send_word(input logic [38:0] pc, input logic [31:0] data);
        logic rdy;
        bit   done;
        done         = 1'b0;
        fetch_v_i    = 1'b1;
        fetch_pc_i   = pc;
        fetch_data_i = data;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            rdy = fetch_ready_o;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        fetch_v_i = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic flush_pulse();
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        flush_i       = 1'b0;
        fetch_v_i     = 1'b0;
        fetch_pc_i    = '0;
        fetch_data_i  = '0;
        instr_ready_i = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        fetch_v_i = 1'b1;
        #1;
        check("rst_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
        check("rst_instr_v", {63'h0, instr_v_o}, 64'd0);
        check("rst_partial", {63'h0, partial_o}, 64'd0);
        check("rst_instr", {32'h0, instr_o}, 64'd0);
        check("rst_pc", {25'h0, instr_pc_o}, 64'd0);
        fetch_v_i = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned 32b instruction
        exp_push(32'h00A00093, 64'h8000_0000, 1'b0, 1'b0);
        send_word(39'h80000000, 32'h00A00093);
        drain();

        // RVC pair in one word, one bubble on fetch_ready_o
        exp_push(32'h00004501, 64'h100, 1'b1, 1'b0);
        exp_push(32'h00004501, 64'h102, 1'b1, 1'b0);
        send_word(39'h100, 32'h45014501);
        check("rvc_bubble", {63'h0, fetch_ready_o}, 64'd0);
        @(posedge clk);
        #1;
        check("rvc_ready_back", {63'h0, fetch_ready_o}, 64'd1);
        drain();

        // Straddling 32b instruction, then a second straddle ending in RVC
        exp_push(32'h00004501, 64'h200, 1'b1, 1'b0);
        send_word(39'h200, 32'h00934501);
        check("straddle_partial", {63'h0, partial_o}, 64'd1);
        exp_push(32'h00A00093, 64'h202, 1'b0, 1'b1);
        send_word(39'h204, 32'hBEEF00A0);
        exp_push(32'h0001BEEF, 64'h206, 1'b0, 1'b1);
        exp_push(32'h00000001, 64'h20A, 1'b1, 1'b0);
        send_word(39'h208, 32'h00010001);
        drain();
        check("straddle_empty", {63'h0, partial_o}, 64'd0);

        // Misaligned redirect target: lower half ignored
        flush_pulse();
        exp_push(32'h00000001, 64'h302, 1'b1, 1'b0);
        send_word(39'h302, 32'h0001FFFF);
        drain();
        check("misalign_partial", {63'h0, partial_o}, 64'd0);

        // Backpressure: output held stable, no word taken
        instr_ready_i = 1'b0;
        exp_push(32'h00A00093, 64'h400, 1'b0, 1'b0);
        send_word(39'h400, 32'h00A00093);
        for (int i = 0; i < 3; i++) begin
            check("bp_instr_v", {63'h0, instr_v_o}, 64'd1);
            check("bp_instr", {32'h0, instr_o}, 64'h00A00093);
            check("bp_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
            @(posedge clk);
            #1;
        end
        instr_ready_i = 1'b1;
        drain();

        // Flush while PARTIAL, with a word offered that must not be consumed
        send_word(39'h502, 32'h0093FFFF);
        check("flush_pre_partial", {63'h0, partial_o}, 64'd1);
        check("flush_pre_instr_v", {63'h0, instr_v_o}, 64'd0);
        fetch_v_i    = 1'b1;
        fetch_pc_i   = 39'h504;
        fetch_data_i = 32'h000100A0;
        flush_i      = 1'b1;
        #1;
        check("flush_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
        @(posedge clk);
        #1;
        flush_i   = 1'b0;
        fetch_v_i = 1'b0;
        check("flush_partial", {63'h0, partial_o}, 64'd0);
        check("flush_instr_v", {63'h0, instr_v_o}, 64'd0);

        // Flush drops a stalled output
        instr_ready_i = 1'b0;
        send_word(39'h600, 32'h00A00093);
        check("flush_out_pre", {63'h0, instr_v_o}, 64'd1);
        flush_pulse();
        check("flush_out_cleared", {63'h0, instr_v_o}, 64'd0);
        instr_ready_i = 1'b1;

        // pc mismatch in PARTIAL: held half dropped
        exp_push(32'h00004501, 64'h400, 1'b1, 1'b0);
        send_word(39'h400, 32'h00934501);
        check("mismatch_partial", {63'h0, partial_o}, 64'd1);
        exp_push(32'h00A00093, 64'h800, 1'b0, 1'b0);
        send_word(39'h800, 32'h00A00093);
        drain();
        check("mismatch_empty", {63'h0, partial_o}, 64'd0);

        // held_pc+2 wraps to zero
        exp_push(32'h00004501, 64'h7F_FFFF_FFFC, 1'b1, 1'b0);
        send_word(39'h7F_FFFF_FFFC, 32'h00934501);
        exp_push(32'h00A00093, 64'h7F_FFFF_FFFE, 1'b0, 1'b1);
        exp_push(32'h00000001, 64'h2, 1'b1, 1'b0);
        send_word(39'h0, 32'h000100A0);
        drain();

        // Back-to-back aligned 32b words
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            d = $urandom | 32'h3;
            exp_push(d, 64'h1000 + 64'(4 * i), 1'b0, 1'b0);
            send_word(39'h1000 + 39'(4 * i), d);
        end
        drain();

        // Random RVC pairs
        for (int i = 0; i < 3; i++) begin
            logic [15:0] h0, h1;
            h0 = 16'($urandom) & 16'hFFFC;
            h1 = 16'($urandom) & 16'hFFFD;
            exp_push({16'h0, h0}, 64'h2000 + 64'(4 * i), 1'b1, 1'b0);
            exp_push({16'h0, h1}, 64'h2002 + 64'(4 * i), 1'b1, 1'b0);
            send_word(39'h2000 + 39'(4 * i), {h1, h0});
        end
        drain();

`ifdef BP_FE_REALIGNER_PERF_EN
        check("perf_rvc", {32'h0, perf_rvc_cnt_o}, 64'(n_rvc));
        check("perf_straddle", {32'h0, perf_straddle_cnt_o}, 64'(n_str));
`endif

        // Asynchronous reset while PARTIAL
        send_word(39'h902, 32'h0093FFFF);
        check("rst_mid_partial_pre", {63'h0, partial_o}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_partial", {63'h0, partial_o}, 64'd0);
        check("rst_mid_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
        check("rst_mid_instr_v", {63'h0, instr_v_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
